inverter_bist_ctrl: RTL and testbench

//   Built-in self-test sequencer for the 1-bit inverter cell. On start, it drives a

---
 rtl/inverter_bist_ctrl_pkg.sv | 22 ++
 rtl/inverter_bist_ctrl_if.sv | 27 ++
 rtl/inverter_bist_ctrl_lfsr8.sv | 26 ++
 rtl/inverter_bist_ctrl.sv | 118 +++++++++++
 tb/tb_inverter_bist_ctrl.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/inverter_bist_ctrl_pkg.sv
// Shared types and constants for the inverter BIST sequencer.
// State encoding, LFSR taps/seed and the LFSR step function.
package inverter_bist_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_APPLY  = 2'd1,
    S_SETTLE = 2'd2,
    S_CHECK  = 2'd3
  } state_t;

  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam logic [7:0] DEF_SEED  = 8'hA5;

  // Fibonacci x^8+x^6+x^5+x^4+1, shifting toward bit 0
  function automatic logic [7:0] lfsr_next(
    input logic [7:0] s
  );
    return {^(s & LFSR_TAPS), s[7:1]};
  endfunction

endpackage

// File: rtl/inverter_bist_ctrl_if.sv
// Control-side bundle between the test controller and the BIST.
// Controller drives start/abort; BIST returns status and counts.
interface inverter_bist_ctrl_if #(
  parameter int ERR_W = 8
) ();

  logic             start;
  logic             abort;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [7:0]       vec_count;

  modport master (
    output start, abort,
    input  busy, done, pass,
    input  err_count, vec_count
  );

  modport slave (
    input  start, abort,
    output busy, done, pass,
    output err_count, vec_count
  );

endinterface

// File: rtl/inverter_bist_ctrl_lfsr8.sv
// 8-bit Fibonacci LFSR pattern source for the inverter BIST.
// load has priority over step; reset returns to SEED.
module lfsr8
  import inverter_bist_ctrl_pkg::*;
#(
  parameter logic [7:0] SEED = DEF_SEED
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       step,
  output logic [7:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= SEED;
    end else if (load) begin
      q <= seed;
    end else if (step) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/inverter_bist_ctrl.sv
// BIST sequencer for a 1-bit inverter cell: drives LFSR bits,
// waits a settle time, checks ~dut_in and counts mismatches.
module inverter_bist_ctrl
  import inverter_bist_ctrl_pkg::*;
#(
  parameter int         NUM_VECTORS   = 16,
  parameter int         SETTLE_CYCLES = 2,
  parameter int         ERR_W         = 8,
  parameter logic [7:0] LFSR_SEED     = DEF_SEED
) (
  input  logic                  clk,
  input  logic                  rst_n,
  inverter_bist_ctrl_if.slave   bus,
  output logic                  dut_in,
  input  logic                  dut_out
);

  localparam logic [7:0] SET_L = 8'(SETTLE_CYCLES);
  localparam logic [7:0] NV_L  = 8'(NUM_VECTORS);

  state_t           r_state;
  logic [7:0]       r_settle;
  logic [7:0]       r_vec;
  logic [ERR_W-1:0] r_err;
  logic             r_dut_in;
  logic             r_done;
  logic             r_pass;

  logic [7:0]       w_lfsr;
  logic             w_go;
  logic             w_step;
  logic             w_load;
  logic             w_mis;
  logic             w_last;
  logic [7:0]       w_vec_nx;
  logic [ERR_W-1:0] w_err_nx;

  assign w_go   = (r_state == S_IDLE) & bus.start & ~bus.abort;
  assign w_step = (r_state == S_CHECK) & ~bus.abort;
  // An all-zero state would lock up; reseed defensively
  assign w_load = w_go | (w_lfsr == 8'd0);

  assign w_mis    = (dut_out == r_dut_in);
  assign w_err_nx = (w_mis && (r_err != '1)) ?
                    r_err + ERR_W'(1) : r_err;
  assign w_vec_nx = r_vec + 8'd1;
  assign w_last   = (w_vec_nx == NV_L);

  lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (w_load),
    .seed  (LFSR_SEED),
    .step  (w_step),
    .q     (w_lfsr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_settle <= 8'd0;
      r_vec    <= 8'd0;
      r_err    <= '0;
      r_dut_in <= 1'b0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
    end else if ((r_state != S_IDLE) && bus.abort) begin
      r_state  <= S_IDLE;
      r_dut_in <= 1'b0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_go) begin
            r_state <= S_APPLY;
            r_err   <= '0;
            r_vec   <= 8'd0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
          end
        end
        S_APPLY: begin
          r_dut_in <= w_lfsr[0];
          r_settle <= SET_L;
          r_state  <= (SET_L == 8'd0) ? S_CHECK : S_SETTLE;
        end
        S_SETTLE: begin
          r_settle <= r_settle - 8'd1;
          if (r_settle <= 8'd1) begin
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          r_err <= w_err_nx;
          r_vec <= w_vec_nx;
          if (w_last) begin
            r_state  <= S_IDLE;
            r_done   <= 1'b1;
            r_pass   <= (w_err_nx == '0);
            r_dut_in <= 1'b0;
          end else begin
            r_state <= S_APPLY;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dut_in        = r_dut_in;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = r_done;
  assign bus.pass      = r_pass;
  assign bus.err_count = r_err;
  assign bus.vec_count = r_vec;

endmodule

// File: tb/tb_inverter_bist_ctrl.sv
// Directed bench for inverter_bist_ctrl with a per-run scoreboard.
// Three instances: defaults with fault models, short run, narrow counter.
module tb_inverter_bist_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int mode0 = 0;

  inverter_bist_ctrl_if #(.ERR_W(8)) bif0 ();
  inverter_bist_ctrl_if #(.ERR_W(8)) bif1 ();
  inverter_bist_ctrl_if #(.ERR_W(2)) bif2 ();

  logic din0, din1, din2;
  logic dout0, dout1, dout2;

  assign dout0 = (mode0 == 0) ? ~din0 :
                 (mode0 == 1) ?  din0 : 1'b0;
  assign dout1 = ~din1;
  assign dout2 = din2;

  inverter_bist_ctrl u0 (
    .clk(clk), .rst_n(rst_n), .bus(bif0),
    .dut_in(din0), .dut_out(dout0)
  );

  inverter_bist_ctrl #(
    .NUM_VECTORS(1), .SETTLE_CYCLES(0)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .bus(bif1),
    .dut_in(din1), .dut_out(dout1)
  );

  inverter_bist_ctrl #(.ERR_W(2)) u2 (
    .clk(clk), .rst_n(rst_n), .bus(bif2),
    .dut_in(din2), .dut_out(dout2)
  );

  typedef struct {
    int lat;
    int err;
    int vec;
    bit pass;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  function automatic int model_err(input int mode,
                                   input int n);
    logic [7:0] l;
    int cnt;
    l = 8'hA5;
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      if (mode == 1) cnt++;
      else if (mode == 2 && l[0] == 1'b0) cnt++;
      l = {l[7] ^ l[5] ^ l[4] ^ l[3], l[7:1]};
    end
    return cnt;
  endfunction

  task automatic set_in(input int w, input logic st,
                        input logic ab);
    case (w)
      0: begin bif0.start = st; bif0.abort = ab; end
      1: begin bif1.start = st; bif1.abort = ab; end
      default: begin bif2.start = st; bif2.abort = ab; end
    endcase
  endtask

  task automatic sample(input int w,
                        output logic bsy, output logic dn,
                        output logic ps,
                        output logic [31:0] er,
                        output logic [31:0] vc,
                        output logic di);
    case (w)
      0: begin
        bsy = bif0.busy; dn = bif0.done; ps = bif0.pass;
        er = 32'(bif0.err_count); vc = 32'(bif0.vec_count);
        di = din0;
      end
      1: begin
        bsy = bif1.busy; dn = bif1.done; ps = bif1.pass;
        er = 32'(bif1.err_count); vc = 32'(bif1.vec_count);
        di = din1;
      end
      default: begin
        bsy = bif2.busy; dn = bif2.done; ps = bif2.pass;
        er = 32'(bif2.err_count); vc = 32'(bif2.vec_count);
        di = din2;
      end
    endcase
  endtask

  logic        o_busy, o_done, o_pass, o_din;
  logic [31:0] o_err, o_vec;

  task automatic pulse_start(input int w);
    @(posedge clk); #1;
    set_in(w, 1'b1, 1'b0);
    @(posedge clk); #1;
    set_in(w, 1'b0, 1'b0);
  endtask

  task automatic run(input string tag, input int w,
                     input int n, input int s,
                     input int err, input bit ps);
    exp_t e;
    int lat;
    e.lat = n * (s + 2);
    e.err = err;
    e.vec = n;
    e.pass = ps;
    sb.push_back(e);
    pulse_start(w);
    sample(w, o_busy, o_done, o_pass, o_err, o_vec, o_din);
    chk({tag, ".busy_start"}, 32'(o_busy), 32'd1);
    lat = 0;
    while (!o_done && lat < 400) begin
      @(posedge clk); #1;
      lat++;
      sample(w, o_busy, o_done, o_pass, o_err, o_vec, o_din);
    end
    e = sb.pop_front();
    chk({tag, ".latency"}, 32'(lat), 32'(e.lat));
    chk({tag, ".err"}, o_err, 32'(e.err));
    chk({tag, ".vec"}, o_vec, 32'(e.vec));
    chk({tag, ".pass"}, 32'(o_pass), 32'(e.pass));
    chk({tag, ".busy_end"}, 32'(o_busy), 32'd0);
    chk({tag, ".din_end"}, 32'(o_din), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    sample(w, o_busy, o_done, o_pass, o_err, o_vec, o_din);
    chk({tag, ".done_held"}, 32'(o_done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    set_in(0, 1'b0, 1'b0);
    set_in(1, 1'b0, 1'b0);
    set_in(2, 1'b0, 1'b0);
    #22;
    sample(0, o_busy, o_done, o_pass, o_err, o_vec, o_din);
    chk("rst.busy", 32'(o_busy), 32'd0);
    chk("rst.done", 32'(o_done), 32'd0);
    chk("rst.pass", 32'(o_pass), 32'd0);
    chk("rst.err", o_err, 32'd0);
    chk("rst.vec", o_vec, 32'd0);
    chk("rst.din", 32'(o_din), 32'd0);
    rst_n = 1'b1;

    mode0 = 0;
    run("good", 0, 16, 2, 0, 1'b1);
    mode0 = 1;
    run("buffer", 0, 16, 2, 16, 1'b0);
    mode0 = 2;
    run("stuck0", 0, 16, 2, model_err(2, 16), 1'b0);

    // abort sampled at the 21st edge after start
    mode0 = 0;
    e.lat = 0; e.err = 0; e.vec = 5; e.pass = 1'b0;
    sb.push_back(e);
    pulse_start(0);
    repeat (20) @(posedge clk);
    #1;
    set_in(0, 1'b0, 1'b1);
    @(posedge clk); #1;
    set_in(0, 1'b0, 1'b0);
    e = sb.pop_front();
    sample(0, o_busy, o_done, o_pass, o_err, o_vec, o_din);
    chk("abort.busy", 32'(o_busy), 32'd0);
    chk("abort.done", 32'(o_done), 32'd0);
    chk("abort.pass", 32'(o_pass), 32'(e.pass));
    chk("abort.din", 32'(o_din), 32'd0);
    chk("abort.vec", o_vec, 32'(e.vec));
    chk("abort.err", o_err, 32'(e.err));
    run("after_abort", 0, 16, 2, 0, 1'b1);

    // start+abort together in IDLE: abort wins
    @(posedge clk); #1;
    set_in(0, 1'b1, 1'b1);
    @(posedge clk); #1;
    set_in(0, 1'b0, 1'b0);
    sample(0, o_busy, o_done, o_pass, o_err, o_vec, o_din);
    chk("start_abort.busy", 32'(o_busy), 32'd0);
    chk("start_abort.done", 32'(o_done), 32'd1);

    // re-pulse while busy, then async reset mid-run
    pulse_start(0);
    repeat (9) @(posedge clk);
    #1;
    set_in(0, 1'b1, 1'b0);
    @(posedge clk); #1;
    set_in(0, 1'b0, 1'b0);
    repeat (19) @(posedge clk);
    #1;
    sample(0, o_busy, o_done, o_pass, o_err, o_vec, o_din);
    chk("repulse.vec", o_vec, 32'd7);
    chk("repulse.busy", 32'(o_busy), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    sample(0, o_busy, o_done, o_pass, o_err, o_vec, o_din);
    chk("midrst.busy", 32'(o_busy), 32'd0);
    chk("midrst.vec", o_vec, 32'd0);
    chk("midrst.din", 32'(o_din), 32'd0);
    chk("midrst.done", 32'(o_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run("post_rst", 0, 16, 2, 0, 1'b1);

    run("short", 1, 1, 0, 0, 1'b1);
    run("sat", 2, 16, 2, 3, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
